// File: rtl/dense_bias_sequencer_pkg.sv
// Shared definitions for the dense bias sequencer: FSM encoding,
// saturation limits and default sizing.
package dense_bias_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACC = 2'd1,
    EMIT     = 2'd2,
    FINISH   = 2'd3
  } state_t;

  localparam int DEFAULT_WORD_SIZE   = 32;
  localparam int DEFAULT_LENGTH_SIZE = 10;
  localparam int DEFAULT_ADR_SIZE    = 4;

  localparam logic [31:0] SAT_POS_LIMIT = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG_LIMIT = 32'h8000_0000;

endpackage

// File: rtl/dense_bias_sequencer_if.sv
// Handshake bundle between the dense layer datapath (master) and the
// bias sequencer (slave).
interface dense_bias_sequencer_if
  import dense_bias_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADR_SIZE  = DEFAULT_ADR_SIZE
);

  logic                 start;
  logic                 busy;
  logic [WORD_SIZE-1:0] accIn;
  logic                 accValid;
  logic                 accReady;
  logic [WORD_SIZE-1:0] outData;
  logic [ADR_SIZE-1:0]  outIdx;
  logic                 outValid;
  logic                 outReady;
  logic [ADR_SIZE-1:0]  classOut;
  logic                 done;

  modport master (
    output start, accIn, accValid, outReady,
    input  busy, accReady, outData, outIdx, outValid, classOut, done
  );

  modport slave (
    input  start, accIn, accValid, outReady,
    output busy, accReady, outData, outIdx, outValid, classOut, done
  );

endinterface

// File: rtl/dense_bias_sequencer_lut.sv
// Constant per-neuron bias table; every addressable entry is driven so an
// out-of-range index can never read an undefined value.
module DenseBiasLut
  import dense_bias_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADR_SIZE  = DEFAULT_ADR_SIZE
) (
  input  logic [ADR_SIZE-1:0]  adr,
  output logic [WORD_SIZE-1:0] dataOut
);

  localparam int TABLE_DEPTH = 16;

  localparam logic [31:0] BIAS_TABLE [TABLE_DEPTH] = '{
    32'h0125_98B0, 32'h0200_0000, 32'hFF00_0000, 32'h0040_0000,
    32'hFFF0_0000, 32'h0012_3456, 32'hFE80_0000, 32'h0080_0000,
    32'h0005_0000, 32'hFFFF_8000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

  // Combinational read: select the table word matching the address.
  always_comb begin
    dataOut = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (adr == ADR_SIZE'(i)) begin
        dataOut = WORD_SIZE'(BIAS_TABLE[i]);
      end
    end
  end

endmodule

// File: rtl/dense_bias_sequencer.sv
// Adds a per-neuron bias to each incoming dot product, saturates it,
// streams it downstream and tracks the argmax across the frame.
module dense_bias_sequencer
  import dense_bias_sequencer_pkg::*;
#(
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int LENGTH_SIZE = DEFAULT_LENGTH_SIZE,
  parameter int ADR_SIZE    = DEFAULT_ADR_SIZE
) (
  input  logic                    clk,
  input  logic                    rstn,
  dense_bias_sequencer_if.slave   bus
);

  localparam logic [WORD_SIZE-1:0] SAT_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] SAT_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic [ADR_SIZE-1:0]  LAST_CNT = ADR_SIZE'(LENGTH_SIZE - 1);

  state_t               state;
  state_t               nextState;
  logic [ADR_SIZE-1:0]  cnt;
  logic [WORD_SIZE-1:0] bias;
  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0] satSum;
  logic [WORD_SIZE-1:0] maxVal;
  logic [ADR_SIZE-1:0]  maxIdx;
  logic                 lastCnt;

  DenseBiasLut #(
    .WORD_SIZE (WORD_SIZE),
    .ADR_SIZE  (ADR_SIZE)
  ) biasLut (
    .adr     (cnt),
    .dataOut (bias)
  );

  assign lastCnt = (cnt == LAST_CNT);

  // Widen by one bit so overflow shows up as a disagreement of the top two bits.
  always_comb begin
    sum    = {bus.accIn[WORD_SIZE-1], bus.accIn} + {bias[WORD_SIZE-1], bias};
    satSum = sum[WORD_SIZE-1:0];
    if (sum[WORD_SIZE] != sum[WORD_SIZE-1]) begin
      satSum = sum[WORD_SIZE] ? SAT_NEG : SAT_POS;
    end
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: accept one word, hold it until taken, repeat per neuron.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (bus.start)    nextState = WAIT_ACC;
      WAIT_ACC: if (bus.accValid) nextState = EMIT;
      EMIT:     if (bus.outReady) nextState = lastCnt ? FINISH : WAIT_ACC;
      FINISH:   nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.accReady = (state == WAIT_ACC);
  end

  // Datapath: capture biased result, update running argmax, publish class.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt          <= '0;
      bus.outData  <= '0;
      bus.outIdx   <= '0;
      bus.outValid <= 1'b0;
      bus.classOut <= '0;
      bus.done     <= 1'b0;
      maxVal       <= '0;
      maxIdx       <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            maxVal <= SAT_NEG;
            maxIdx <= '0;
          end
        end
        WAIT_ACC: begin
          if (bus.accValid) begin
            bus.outData  <= satSum;
            bus.outIdx   <= cnt;
            bus.outValid <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.outReady) begin
            bus.outValid <= 1'b0;
            if ($signed(bus.outData) > $signed(maxVal)) begin
              maxVal <= bus.outData;
              maxIdx <= bus.outIdx;
            end
            if (!lastCnt) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FINISH: begin
          bus.classOut <= maxIdx;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_bias_sequencer.sv
// Randomised self-checking bench for dense_bias_sequencer. Two instances:
// a full 10-neuron layer and a 2-neuron layer for classification cases.
module tb_dense_bias_sequencer;
  import dense_bias_sequencer_pkg::*;

  localparam logic [31:0] BIAS_REF [10] = '{
    32'h0125_98B0, 32'h0200_0000, 32'hFF00_0000, 32'h0040_0000,
    32'hFFF0_0000, 32'h0012_3456, 32'hFE80_0000, 32'h0080_0000,
    32'h0005_0000, 32'hFFFF_8000
  };

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] accIn;
  logic        accValid;
  logic        outReady;
  bit          selB;

  int checks;
  int failures;

  dense_bias_sequencer_if #(.WORD_SIZE(32), .ADR_SIZE(4)) busA ();
  dense_bias_sequencer_if #(.WORD_SIZE(32), .ADR_SIZE(4)) busB ();

  dense_bias_sequencer #(.WORD_SIZE(32), .LENGTH_SIZE(10), .ADR_SIZE(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busA.slave)
  );

  dense_bias_sequencer #(.WORD_SIZE(32), .LENGTH_SIZE(2), .ADR_SIZE(4)) dutB (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busB.slave)
  );

  assign busA.start    = start & ~selB;
  assign busB.start    = start & selB;
  assign busA.accValid = accValid & ~selB;
  assign busB.accValid = accValid & selB;
  assign busA.accIn    = accIn;
  assign busB.accIn    = accIn;
  assign busA.outReady = outReady;
  assign busB.outReady = outReady;

  wire        curBusy     = selB ? busB.busy     : busA.busy;
  wire        curAccReady = selB ? busB.accReady : busA.accReady;
  wire [31:0] curOutData  = selB ? busB.outData  : busA.outData;
  wire [3:0]  curOutIdx   = selB ? busB.outIdx   : busA.outIdx;
  wire        curOutValid = selB ? busB.outValid : busA.outValid;
  wire [3:0]  curClassOut = selB ? busB.classOut : busA.classOut;
  wire        curDone     = selB ? busB.done     : busA.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact sum of word and bias, clamped to the signed 32-bit range.
  function automatic logic [31:0] modelOut(input logic [31:0] acc, input int idx);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(BIAS_REF[idx]));
    if (s > longint'($signed(SAT_POS_LIMIT))) return SAT_POS_LIMIT;
    if (s < longint'($signed(SAT_NEG_LIMIT))) return SAT_NEG_LIMIT;
    return s[31:0];
  endfunction

  // Runs one frame on the selected instance and checks every emitted word.
  task automatic runFrame(input bit useB, input int n, input logic [31:0] accs [10],
                          input int stallIdx, input int stallLen,
                          output logic [31:0] obs [10], output logic [3:0] cls);
    logic [31:0] expOut [10];
    logic [31:0] best;
    int          bestIdx;
    int          guard;
    int          doneSeen;
    selB = useB;
    for (int i = 0; i < 10; i++) begin
      obs[i]    = '0;
      expOut[i] = modelOut(accs[i], i);
    end
    best = expOut[0];
    bestIdx = 0;
    for (int i = 1; i < n; i++) begin
      if ($signed(expOut[i]) > $signed(best)) begin
        best = expOut[i];
        bestIdx = i;
      end
    end
    cls = '0;
    @(negedge clk);
    start = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (curAccReady !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (curAccReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL accReady_wait n%0d: got %b expected 1", i, curAccReady);
      end
      accIn = accs[i];
      accValid = 1'b1;
      outReady = (stallLen > 0 && i == stallIdx) ? 1'b0 : 1'b1;
      @(negedge clk);
      accValid = 1'b0;
      accIn = '0;
      obs[i] = curOutData;
      checks++;
      if (curOutValid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL outValid_latency n%0d: got %b expected 1", i, curOutValid);
      end
      checks++;
      if (curOutData !== expOut[i]) begin
        failures++;
        $display("[TB] FAIL outData n%0d: got %h expected %h", i, curOutData, expOut[i]);
      end
      checks++;
      if (curOutIdx !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL outIdx n%0d: got %0d expected %0d", i, curOutIdx, i);
      end
      if (stallLen > 0 && i == stallIdx) begin
        for (int k = 0; k < stallLen; k++) begin
          start = (k % 2 == 0);
          @(negedge clk);
          checks++;
          if (curOutValid !== 1'b1 || curOutData !== expOut[i] || curOutIdx !== 4'(i)
              || curAccReady !== 1'b0 || curBusy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_hold n%0d k%0d: got v%b d%h i%0d r%b b%b expected v1 d%h i%0d r0 b1",
                     i, k, curOutValid, curOutData, curOutIdx, curAccReady, curBusy, expOut[i], i);
          end
        end
        start = 1'b0;
        outReady = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (curOutValid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL outValid_drop n%0d: got %b expected 0", i, curOutValid);
      end
    end
    doneSeen = 0;
    for (int k = 0; k < 5; k++) begin
      if (curDone === 1'b1) begin
        doneSeen++;
        cls = curClassOut;
      end
      @(negedge clk);
    end
    checks++;
    if (doneSeen != 1) begin
      failures++;
      $display("[TB] FAIL done_pulse: got %0d cycles expected 1", doneSeen);
    end
    checks++;
    if (cls !== 4'(bestIdx)) begin
      failures++;
      $display("[TB] FAIL classOut: got %0d expected %0d", cls, bestIdx);
    end
    checks++;
    if (curBusy !== 1'b0 || curClassOut !== 4'(bestIdx)) begin
      failures++;
      $display("[TB] FAIL idle_after_frame: got busy %b class %0d expected busy 0 class %0d",
               curBusy, curClassOut, bestIdx);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      selB = (s == 1);
      #1;
      checks++;
      if ({curBusy, curAccReady, curOutValid, curDone} !== 4'b0000
          || curOutData !== 32'h0 || curOutIdx !== 4'h0 || curClassOut !== 4'h0) begin
        failures++;
        $display("[TB] FAIL reset_state inst%0d: got b%b r%b v%b d%b data %h idx %0d cls %0d expected all 0",
                 s, curBusy, curAccReady, curOutValid, curDone, curOutData, curOutIdx, curClassOut);
      end
    end
    selB = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_first_neuron();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    for (int i = 0; i < 10; i++) accs[i] = $urandom_range(0, 32'h00FF_FFFF);
    accs[0] = 32'h0;
    runFrame(1'b0, 10, accs, 0, 0, obs, cls);
    checks++;
    if (obs[0] !== 32'h0125_98B0) begin
      failures++;
      $display("[TB] FAIL first_neuron: got %h expected 012598b0", obs[0]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    for (int i = 0; i < 10; i++) accs[i] = $urandom();
    accs[1] = 32'h7FFF_FFFF;
    accs[2] = 32'h8000_0000;
    runFrame(1'b0, 10, accs, 0, 0, obs, cls);
    checks++;
    if (obs[1] !== 32'h7FFF_FFFF) begin
      failures++;
      $display("[TB] FAIL sat_pos: got %h expected 7fffffff", obs[1]);
    end
    checks++;
    if (obs[2] !== 32'h8000_0000) begin
      failures++;
      $display("[TB] FAIL sat_neg: got %h expected 80000000", obs[2]);
    end
  endtask

  task automatic test_classify();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    for (int i = 0; i < 10; i++) accs[i] = '0;
    accs[0] = 32'h0B00_0000;
    runFrame(1'b1, 2, accs, 0, 0, obs, cls);
    checks++;
    if (cls !== 4'd0) begin
      failures++;
      $display("[TB] FAIL classify_a: got %0d expected 0", cls);
    end
    accs[0] = 32'h0;
    runFrame(1'b1, 2, accs, 0, 0, obs, cls);
    checks++;
    if (cls !== 4'd1) begin
      failures++;
      $display("[TB] FAIL classify_b: got %0d expected 1", cls);
    end
    selB = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    for (int i = 0; i < 10; i++) accs[i] = $urandom();
    runFrame(1'b0, 10, accs, 3, 5, obs, cls);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    int          doneSeen;
    selB = 1'b0;
    @(negedge clk);
    start = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accIn = 32'h1234_5678;
    accValid = 1'b1;
    @(negedge clk);
    accValid = 1'b0;
    @(negedge clk);
    checks++;
    if (curAccReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midframe_wait: got accReady %b expected 1", curAccReady);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({curBusy, curAccReady, curOutValid, curDone} !== 4'b0000
        || curOutData !== 32'h0 || curOutIdx !== 4'h0 || curClassOut !== 4'h0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: got b%b r%b v%b d%b data %h idx %0d cls %0d expected all 0",
               curBusy, curAccReady, curOutValid, curDone, curOutData, curOutIdx, curClassOut);
    end
    rstn = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (curDone === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL midframe_no_done: got %0d pulses expected 0", doneSeen);
    end
    for (int i = 0; i < 10; i++) accs[i] = $urandom();
    runFrame(1'b0, 10, accs, 0, 0, obs, cls);
  endtask

  task automatic test_tie();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    for (int i = 0; i < 10; i++) accs[i] = 32'hC000_0000 + $urandom_range(0, 255);
    accs[0] = 32'h1000_0000;
    accs[1] = 32'h1000_0000 + BIAS_REF[0] - BIAS_REF[1];
    runFrame(1'b0, 10, accs, 0, 0, obs, cls);
    checks++;
    if (obs[0] !== obs[1] || cls !== 4'd0) begin
      failures++;
      $display("[TB] FAIL tie: got %h/%h class %0d expected equal values class 0", obs[0], obs[1], cls);
    end
  endtask

  task automatic test_random();
    logic [31:0] accs [10];
    logic [31:0] obs [10];
    logic [3:0]  cls;
    int          pick;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 10; i++) begin
        pick = $urandom_range(0, 7);
        if (pick == 0) accs[i] = 32'h7FFF_FFFF;
        else if (pick == 1) accs[i] = 32'h8000_0000;
        else accs[i] = $urandom();
      end
      runFrame(1'b0, 10, accs, $urandom_range(0, 9), $urandom_range(0, 3), obs, cls);
    end
  endtask

  // Watchdog so a stuck design still ends the run with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    start = 1'b0;
    accIn = '0;
    accValid = 1'b0;
    outReady = 1'b1;
    selB = 1'b0;
    test_reset();
    test_first_neuron();
    test_saturation();
    test_classify();
    test_stall();
    test_reset_midframe();
    test_tie();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
